// File: rtl/apb_mux_pkg.sv
// apb_mux_pkg: shared types and widths for the APB slave mux with timeout watchdog
//   state_t   - access FSM states (IDLE, WAIT, ABORT)
//   MAX_PORTS - upper bound on slave ports
//   DEC_W     - width of the address decode field
//   CNT_W     - width of the wait-cycle counter
//   FAULT_W   - width of the saturating fault counter
package apb_mux_pkg;
    localparam int MAX_PORTS = 16;
    localparam int DEC_W     = 4;
    localparam int CNT_W     = 16;
    localparam int FAULT_W   = 8;
    typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;
endpackage

// File: rtl/apb_tmo_counter.sv
// apb_tmo_counter: wait-cycle counter with timeout compare, plus saturating fault counter
//   clk, rst   - clock, synchronous active-high reset
//   clr_cnt    - clear the wait counter (access not in WAIT next cycle)
//   inc_cnt    - count one stalled access-phase cycle
//   inc_fault  - count one error completion generated by the mux
//   clr_fault  - clear fault_cnt; wins over inc_fault
//   tmo_hit    - wait counter has reached TIMEOUT-1 (never when TIMEOUT=0)
//   fault_cnt  - saturating error-completion count
module apb_tmo_counter
    import apb_mux_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_cnt,
    input  logic               inc_cnt,
    input  logic               inc_fault,
    input  logic               clr_fault,
    output logic               tmo_hit,
    output logic [FAULT_W-1:0] fault_cnt
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    assign tmo_hit = (TIMEOUT != 0) && (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clr_cnt)
            cnt <= '0;
        else if (inc_cnt)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clr_fault)
            fault_cnt <= '0;
        else if (inc_fault && fault_cnt != '1)
            fault_cnt <= fault_cnt + 1'b1;
    end
endmodule

// File: rtl/apb_slave_mux_tmo.sv
// apb_slave_mux_tmo: APB slave mux decoding paddr to NUM_PORTS slaves, with per-access timeout abort
//   apb_root_clk, apb_root_rst - clock, synchronous active-high reset
//   paddr, psel, penable       - master request
//   prdata, pready, pslverr    - muxed response to master
//   psel_o                     - per-slave select
//   pready_i, prdata_i, pslverr_i - per-slave responses (prdata_i port i at [32i+31:32i])
//   tmo_flag, tmo_port         - sticky timeout flag and last timed-out port
//   fault_cnt                  - saturating count of generated error completions
//   tmo_clr                    - clears tmo_flag, tmo_port and fault_cnt
module apb_slave_mux_tmo
    import apb_mux_pkg::*;
#(
    parameter int                   NUM_PORTS = 16,
    parameter int                   DEC_LSB   = 12,
    parameter logic [MAX_PORTS-1:0] PORT_EN   = 16'h0001,
    parameter int unsigned          TIMEOUT   = 256
) (
    input  logic                    apb_root_clk,
    input  logic                    apb_root_rst,
    input  logic [31:0]             paddr,
    input  logic                    psel,
    input  logic                    penable,
    output logic [31:0]             prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [NUM_PORTS-1:0]    psel_o,
    input  logic [NUM_PORTS-1:0]    pready_i,
    input  logic [32*NUM_PORTS-1:0] prdata_i,
    input  logic [NUM_PORTS-1:0]    pslverr_i,
    output logic                    tmo_flag,
    output logic [DEC_W-1:0]        tmo_port,
    output logic [FAULT_W-1:0]      fault_cnt,
    input  logic                    tmo_clr
);
    state_t               state_q, state_d;
    logic [DEC_W-1:0]     idx;
    logic                 mapped, access, sel_rdy, err_cpl, tmo_hit;
    logic [MAX_PORTS-1:0] rdy_pad, err_pad;
    logic [31:0]          rd_pad [MAX_PORTS];
    logic                 unused_paddr;

    assign unused_paddr = ^paddr;
    assign idx    = paddr[DEC_LSB+DEC_W-1:DEC_LSB];
    assign mapped = (int'(idx) < NUM_PORTS) && PORT_EN[idx];
    assign access = psel && penable;

    // Pad slave responses to MAX_PORTS so any 4-bit idx indexes safely.
    for (genvar i = 0; i < MAX_PORTS; i++) begin : g_pad
        if (i < NUM_PORTS) begin : g_on
            assign rdy_pad[i] = pready_i[i];
            assign err_pad[i] = pslverr_i[i];
            assign rd_pad[i]  = prdata_i[32*i +: 32];
        end else begin : g_off
            assign rdy_pad[i] = 1'b0;
            assign err_pad[i] = 1'b0;
            assign rd_pad[i]  = '0;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_sel
        assign psel_o[i] = psel && mapped && (idx == DEC_W'(i)) && (state_q != ABORT);
    end

    assign sel_rdy = rdy_pad[idx];
    // ABORT overrides the slave; any late pready_i in that cycle is ignored.
    assign err_cpl = (state_q == ABORT) || !mapped;
    assign pready  = !psel || err_cpl || sel_rdy;
    assign pslverr = psel && (err_cpl || err_pad[idx]);
    assign prdata  = (psel && !err_cpl) ? rd_pad[idx] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access && mapped && !sel_rdy) state_d = tmo_hit ? ABORT : WAIT;
            WAIT:    if (!psel || sel_rdy) state_d = IDLE;
                     else if (penable && tmo_hit) state_d = ABORT;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge apb_root_clk) begin
        if (apb_root_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge apb_root_clk) begin
        if (apb_root_rst || tmo_clr) begin
            tmo_flag <= 1'b0;
            tmo_port <= '0;
        end else if (state_q != ABORT && state_d == ABORT) begin
            tmo_flag <= 1'b1;
            tmo_port <= idx;
        end
    end

    // The counter only survives while the access stays in WAIT.
    apb_tmo_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk       (apb_root_clk),
        .rst       (apb_root_rst),
        .clr_cnt   (state_d != WAIT),
        .inc_cnt   (access && !sel_rdy),
        .inc_fault ((access && !mapped) || state_q == ABORT),
        .clr_fault (tmo_clr),
        .tmo_hit   (tmo_hit),
        .fault_cnt (fault_cnt)
    );
endmodule

// File: tb/tb_apb_slave_mux_tmo.sv
// tb_apb_slave_mux_tmo: directed self-checking bench for apb_slave_mux_tmo (4 ports, en=0101, TIMEOUT=8)
module tb_apb_slave_mux_tmo;
    import apb_mux_pkg::*;

    logic         clk = 1'b0;
    logic         rst, psel, penable, tmo_clr;
    logic [31:0]  paddr, prdata;
    logic         pready, pslverr, tmo_flag;
    logic [3:0]   psel_o, pready_i, pslverr_i, tmo_port;
    logic [127:0] prdata_i;
    logic [7:0]   fault_cnt;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    apb_slave_mux_tmo #(
        .NUM_PORTS(4), .DEC_LSB(12), .PORT_EN(16'h0005), .TIMEOUT(8)
    ) dut (
        .apb_root_clk(clk), .apb_root_rst(rst), .paddr(paddr), .psel(psel),
        .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .psel_o(psel_o), .pready_i(pready_i), .prdata_i(prdata_i),
        .pslverr_i(pslverr_i), .tmo_flag(tmo_flag), .tmo_port(tmo_port),
        .fault_cnt(fault_cnt), .tmo_clr(tmo_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic e, input logic [3:0] i);
        psel    = s;
        penable = e;
        paddr   = 32'(i) << 12;
    endtask

    initial begin
        rst = 1'b1; tmo_clr = 1'b0; pready_i = 4'hF; pslverr_i = 4'h0;
        prdata_i = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hCAFE_0001};
        drive(0, 0, 0);
        step();
        @(negedge clk);
        chk("rst_pready", 32'(pready), 1);
        chk("rst_pslverr", 32'(pslverr), 0);
        chk("rst_prdata", prdata, 0);
        chk("rst_psel_o", 32'(psel_o), 0);
        chk("rst_tmo_flag", 32'(tmo_flag), 0);
        chk("rst_tmo_port", 32'(tmo_port), 0);
        chk("rst_fault", 32'(fault_cnt), 0);
        step();
        rst = 1'b0;
        // unmapped by PORT_EN (idx 2 disabled? no: en=0101 -> idx 1 and 3 disabled)
        drive(1, 0, 1);
        @(negedge clk);
        chk("unm_setup_psel_o", 32'(psel_o), 0);
        step();
        drive(1, 1, 1);
        @(negedge clk);
        chk("unm_pready", 32'(pready), 1);
        chk("unm_pslverr", 32'(pslverr), 1);
        chk("unm_prdata", prdata, 0);
        chk("unm_psel_o", 32'(psel_o), 0);
        chk("unm_fault_pre", 32'(fault_cnt), 0);
        step();
        drive(0, 0, 0);
        @(negedge clk);
        chk("unm_fault_post", 32'(fault_cnt), 1);
        step();
        // idx beyond NUM_PORTS
        drive(1, 0, 5);
        step();
        drive(1, 1, 5);
        @(negedge clk);
        chk("oob_pready", 32'(pready), 1);
        chk("oob_pslverr", 32'(pslverr), 1);
        step();
        drive(0, 0, 0);
        @(negedge clk);
        chk("oob_fault", 32'(fault_cnt), 2);
        step();
        // port 0, three wait states
        pready_i = 4'b1110;
        drive(1, 0, 0);
        @(negedge clk);
        chk("ws_setup_psel_o", 32'(psel_o), 32'h1);
        step();
        for (int k = 1; k <= 3; k++) begin
            drive(1, 1, 0);
            @(negedge clk);
            chk($sformatf("ws_wait%0d_pready", k), 32'(pready), 0);
            chk($sformatf("ws_wait%0d_psel_o", k), 32'(psel_o), 32'h1);
            step();
        end
        pready_i = 4'b1111;
        @(negedge clk);
        chk("ws_done_pready", 32'(pready), 1);
        chk("ws_done_pslverr", 32'(pslverr), 0);
        chk("ws_done_prdata", prdata, 32'hCAFE_0001);
        step();
        drive(0, 0, 0);
        @(negedge clk);
        chk("ws_tmo_flag", 32'(tmo_flag), 0);
        chk("ws_fault", 32'(fault_cnt), 2);
        step();
        // slave error passes through without counting as a fault
        pslverr_i = 4'b0001;
        drive(1, 0, 0);
        step();
        drive(1, 1, 0);
        @(negedge clk);
        chk("serr_pslverr", 32'(pslverr), 1);
        step();
        pslverr_i = 4'b0000;
        drive(0, 0, 0);
        @(negedge clk);
        chk("serr_fault", 32'(fault_cnt), 2);
        step();
        // port 2 stalls until timeout; late ready in the abort cycle is ignored
        pready_i = 4'b1011;
        drive(1, 0, 2);
        step();
        for (int k = 1; k <= 8; k++) begin
            drive(1, 1, 2);
            @(negedge clk);
            chk($sformatf("tmo_wait%0d_psel_o", k), 32'(psel_o), 32'h4);
            chk($sformatf("tmo_wait%0d_pready", k), 32'(pready), 0);
            step();
        end
        pready_i = 4'b1111;
        @(negedge clk);
        chk("tmo_abort_psel_o", 32'(psel_o), 0);
        chk("tmo_abort_pready", 32'(pready), 1);
        chk("tmo_abort_pslverr", 32'(pslverr), 1);
        chk("tmo_abort_prdata", prdata, 0);
        chk("tmo_abort_flag", 32'(tmo_flag), 1);
        step();
        // back-to-back setup right after abort
        drive(1, 0, 0);
        @(negedge clk);
        chk("b2b_tmo_port", 32'(tmo_port), 2);
        chk("b2b_fault", 32'(fault_cnt), 3);
        chk("b2b_setup_psel_o", 32'(psel_o), 32'h1);
        step();
        drive(1, 1, 0);
        @(negedge clk);
        chk("b2b_pready", 32'(pready), 1);
        chk("b2b_pslverr", 32'(pslverr), 0);
        chk("b2b_prdata", prdata, 32'hCAFE_0001);
        step();
        // saturation
        for (int k = 0; k < 300; k++) begin
            drive(1, 0, 3);
            step();
            drive(1, 1, 3);
            step();
        end
        drive(0, 0, 0);
        @(negedge clk);
        chk("sat_fault", 32'(fault_cnt), 255);
        step();
        // clear wins over a same-cycle fault
        drive(1, 0, 1);
        step();
        drive(1, 1, 1);
        tmo_clr = 1'b1;
        step();
        tmo_clr = 1'b0;
        drive(0, 0, 0);
        @(negedge clk);
        chk("clr_fault", 32'(fault_cnt), 0);
        chk("clr_tmo_flag", 32'(tmo_flag), 0);
        chk("clr_tmo_port", 32'(tmo_port), 0);
        step();
        // reset during access cycle 5 of a stall
        pready_i = 4'b1011;
        drive(1, 0, 2);
        step();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, 2);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        pready_i = 4'b1111;
        drive(0, 0, 0);
        @(negedge clk);
        chk("mrst_state", 32'(dut.state_q), 32'(IDLE));
        chk("mrst_cnt", 32'(dut.u_cnt.cnt), 0);
        chk("mrst_tmo_flag", 32'(tmo_flag), 0);
        chk("mrst_fault", 32'(fault_cnt), 0);
        step();
        // fresh access with seven waits must finish normally
        pready_i = 4'b1011;
        drive(1, 0, 2);
        step();
        for (int k = 1; k <= 7; k++) begin
            drive(1, 1, 2);
            @(negedge clk);
            chk($sformatf("fresh_wait%0d_pready", k), 32'(pready), 0);
            step();
        end
        pready_i = 4'b1111;
        @(negedge clk);
        chk("fresh_pready", 32'(pready), 1);
        chk("fresh_pslverr", 32'(pslverr), 0);
        chk("fresh_prdata", prdata, 32'hCCCC_0002);
        step();
        drive(0, 0, 0);
        @(negedge clk);
        chk("fresh_tmo_flag", 32'(tmo_flag), 0);
        chk("fresh_fault", 32'(fault_cnt), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
